// File: rtl/gpio_hex_display_if.sv
// CPU-side GPIO bus for the hex display: write port in, committed state out.
// The CPU drives the master side; the display is the slave.
interface gpio_hex_display_if;
    logic [31:0] gpio_data;
    logic        gpio_we;
    logic        pending;
    logic [31:0] shown;

    modport master (
        output gpio_data,
        output gpio_we,
        input  pending,
        input  shown
    );

    modport slave (
        input  gpio_data,
        input  gpio_we,
        output pending,
        output shown
    );
endinterface

// File: rtl/gpio_hex_display.sv
// Eight-digit multiplexed hex display for the GPIO output word.
// Writes are staged and only committed when the scan wraps, so frames never tear.
module gpio_hex_display #(
    parameter int CLK_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst,
    gpio_hex_display_if.slave   bus,
    input  logic                blank_lz,
    output logic [7:0]          hex_an,
    output logic [6:0]          hex_seg
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   staged_q, staged_d;
    logic [31:0]   shown_q, shown_d;
    logic          pending_q, pending_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic          tick;
    logic          commit;
    logic [31:0]   upper;
    logic [3:0]    nib;
    logic          lz;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h7F;
        unique case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        tick    = (presc_q == PMAX);
        commit  = tick && (idx_q == 3'd7);
        presc_d = tick ? '0 : presc_q + PW'(1);
        idx_d   = tick ? idx_q + 3'd1 : idx_q;

        staged_d  = staged_q;
        pending_d = pending_q;
        shown_d   = shown_q;

        if (bus.gpio_we) begin
            staged_d  = bus.gpio_data;
            pending_d = 1'b1;
        end

        // A write landing on the commit edge bypasses the stage.
        if (commit) begin
            pending_d = 1'b0;
            if (bus.gpio_we) begin
                shown_d = bus.gpio_data;
            end else if (pending_q) begin
                shown_d = staged_q;
            end
        end
    end

    always_comb begin
        upper = shown_q >> {idx_q, 2'b00};
        nib   = upper[3:0];
        // Blank when this digit and every more-significant one are zero.
        lz    = blank_lz && (idx_q != 3'd0) && (upper == 32'd0);
        an_d  = ~(8'd1 << idx_q);
        seg_d = lz ? 7'h7F : hex7(nib);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            idx_q     <= 3'd0;
            staged_q  <= 32'd0;
            shown_q   <= 32'd0;
            pending_q <= 1'b0;
            an_q      <= 8'hFE;
            seg_q     <= 7'h40;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            staged_q  <= staged_d;
            shown_q   <= shown_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign hex_an      = an_q;
    assign hex_seg     = seg_q;
    assign bus.pending = pending_q;
    assign bus.shown   = shown_q;

endmodule

// File: tb/tb_gpio_hex_display.sv
// Directed bench for gpio_hex_display with CLK_DIV=4 (frame = 32 cycles).
// t counts rising edges since reset release; commits land on t = 32*m.
module tb_gpio_hex_display;

    logic       clk;
    logic       rst;
    logic       blank_lz;
    logic [7:0] hex_an;
    logic [6:0] hex_seg;

    int n_checks;
    int n_fails;
    int t;

    gpio_hex_display_if bus ();

    gpio_hex_display #(.CLK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .blank_lz (blank_lz),
        .hex_an   (hex_an),
        .hex_seg  (hex_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic goto(input int target);
        while (t < target) step();
    endtask

    task automatic write(input logic [31:0] d);
        bus.gpio_data = d;
        bus.gpio_we   = 1'b1;
        step();
        bus.gpio_we   = 1'b0;
    endtask

    task automatic digit(input string tag, input int k, input logic [6:0] s);
        check({tag, "_an"}, {24'd0, hex_an}, {24'd0, ~(8'd1 << k)});
        check({tag, "_seg"}, {25'd0, hex_seg}, {25'd0, s});
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        t        = 0;
        rst      = 1'b1;
        blank_lz = 1'b0;
        bus.gpio_data = 32'd0;
        bus.gpio_we   = 1'b0;

        // 1: reset state and anode walk
        step();
        step();
        check("rst_an", {24'd0, hex_an}, 32'h0000_00FE);
        check("rst_seg", {25'd0, hex_seg}, 32'h0000_0040);
        check("rst_shown", bus.shown, 32'd0);
        check("rst_pend", {31'd0, bus.pending}, 32'd0);
        rst = 1'b0;
        t = 0;
        goto(4);
        check("walk_hold", {24'd0, hex_an}, 32'h0000_00FE);
        for (int k = 0; k < 8; k++) begin
            goto(4 * k + 1);
            digit("walk", k, 7'h40);
        end

        // 2: single write, held until the frame boundary
        goto(39);
        write(32'h1234_5678);
        check("w1_pend", {31'd0, bus.pending}, 32'd1);
        check("w1_hold", bus.shown, 32'd0);
        goto(63);
        check("w1_pre", bus.shown, 32'd0);
        goto(64);
        check("w1_shown", bus.shown, 32'h1234_5678);
        check("w1_clr", {31'd0, bus.pending}, 32'd0);
        goto(65);
        digit("w1_d0", 0, 7'h00);
        goto(93);
        digit("w1_d7", 7, 7'h79);

        // 3: last write wins
        goto(100);
        write(32'hAAAA_0000);
        write(32'h0000_BEEF);
        goto(128);
        check("lww_shown", bus.shown, 32'h0000_BEEF);
        goto(129);
        digit("lww_d0", 0, 7'h0E);
        goto(133);
        digit("lww_d1", 1, 7'h06);
        goto(137);
        digit("lww_d2", 2, 7'h06);
        goto(141);
        digit("lww_d3", 3, 7'h03);

        // 4: write on the exact commit edge bypasses the stage
        goto(149);
        write(32'h1111_1111);
        goto(159);
        write(32'hDEAD_BEEF);
        check("byp_shown", bus.shown, 32'hDEAD_BEEF);
        check("byp_pend", {31'd0, bus.pending}, 32'd0);

        // 5: leading-zero blanking
        goto(169);
        write(32'h0000_00A5);
        goto(180);
        blank_lz = 1'b1;
        goto(192);
        check("stg_after_byp", bus.shown, 32'h0000_00A5);
        goto(193);
        digit("lz_d0", 0, 7'h12);
        goto(197);
        digit("lz_d1", 1, 7'h08);
        for (int k = 2; k < 8; k++) begin
            goto(4 * k + 193);
            digit("lz_blank", k, 7'h7F);
        end
        goto(223);
        write(32'h0000_0000);
        goto(225);
        digit("lz0_d0", 0, 7'h40);
        for (int k = 1; k < 8; k++) begin
            goto(4 * k + 225);
            digit("lz0_blank", k, 7'h7F);
        end
        goto(254);
        blank_lz = 1'b0;
        for (int k = 0; k < 8; k++) begin
            goto(4 * k + 257);
            digit("nolz", k, 7'h40);
        end

        // 6: reset discards a pending write
        goto(289);
        write(32'hFFFF_FFFF);
        check("rw_pend", {31'd0, bus.pending}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        t = 0;
        check("rw_pend0", {31'd0, bus.pending}, 32'd0);
        check("rw_shown", bus.shown, 32'd0);
        check("rw_an", {24'd0, hex_an}, 32'h0000_00FE);
        check("rw_seg", {25'd0, hex_seg}, 32'h0000_0040);
        goto(40);
        check("rw_never", bus.shown, 32'd0);
        check("rw_idle", {31'd0, bus.pending}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/gpio_hex_display.md
Name: gpio_hex_display

Overview:
- Reader/consumer end of the CPU's GPIO output port. Accepts 32-bit words written by the CPU (data + write strobe) and shows them as 8 hex digits on a time-multiplexed, active-low 7-segment display.
- New values are committed only at frame boundaries, so a frame never mixes old and new nibbles (no tearing).
- Sits between the cpu top-level GPIO output and board display pins.

Parameters:
CLK_DIV, 50000, clock cycles each digit stays lit (per-digit dwell); legal range >= 2. Benches use 4.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
gpio_data  input  32  word written by CPU GPIO port
gpio_we  input  1  one-cycle write strobe qualifying gpio_data
blank_lz  input  1  1 = blank leading-zero digits; sampled every cycle
hex_an  output  8  digit enables, active-low, bit k = digit k (digit 0 = least significant nibble)
hex_seg  output  7  segments, active-low, bit6..bit0 = g,f,e,d,c,b,a
pending  output  1  staged write waiting for frame boundary
shown  output  32  value currently being displayed (committed)

Behaviour:
- Reset (rst=1 at a rising edge): prescaler=0, idx=0, staged=0, shown=0, pending=0, hex_an=8'hFE, hex_seg=7'h40. Any pending write is discarded. Reset has priority over all other events.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick=1 when prescaler==CLK_DIV-1.
  - On tick, idx <= (idx+1) mod 8.
  - One frame = 8*CLK_DIV cycles.
- Write: gpio_we=1 -> staged <= gpio_data, pending <= 1. Multiple writes before commit: last write wins.
- Commit event: tick && idx==7 (same edge idx wraps 7->0).
  - shown <= staged, pending <= 0.
  - If gpio_we=1 on the commit edge: shown <= gpio_data (bypass), staged <= gpio_data, pending <= 0.
  - Commit with pending=0: shown unchanged.
- Outputs are registered with 1-cycle latency from the idx/shown registers.
  - hex_an = ~(1<<idx).
  - hex_seg = decode of nibble shown[4*idx+3:4*idx].
  - Exactly one hex_an bit is low at all times after reset.
- Hex decode (active-low, hex values):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero blanking: for idx k in 1..7, if blank_lz=1 and nibbles k..7 of shown are all zero, hex_seg <= 7'h7F (anode still driven). Digit 0 is never blanked.
- shown and pending are direct register outputs with no extra latency.
- idx never takes values outside 0..7. Prescaler never exceeds CLK_DIV-1.

Test Plan:
1. Reset (CLK_DIV=4): hold rst 2 cycles -> hex_an=FE, hex_seg=40, shown=0, pending=0. Then free-run 32 cycles -> hex_an walks FE,FD,FB,...,7F, 4 cycles each, seg=40 throughout.
2. Write 0x12345678 mid-frame -> pending=1 the next cycle and shown stays 0 until the idx 7->0 edge; then shown=12345678, pending=0. Next frame: digit0 seg=00 with an=FE; digit7 seg=79 with an=7F.
3. Write 0xAAAA0000 then 0x0000BEEF before the boundary -> after commit shown=0000BEEF. Digits 0..3 show 0E, 06, 06, 03.
4. gpio_we=1 with 0xDEADBEEF on the exact commit edge (tick, idx=7) -> shown=DEADBEEF on that edge, pending=0 the same cycle.
5. blank_lz=1, shown=0x000000A5 -> digit0=12, digit1=08, digits 2..7=7F. With shown=0: digit0=40, digits 1..7=7F. With blank_lz=0: all zero digits show 40.
6. Write 0xFFFFFFFF, then assert rst while pending=1 -> next edge pending=0, shown=0, hex_an=FE, hex_seg=40. The write is never displayed.
